reduction_tree_arbiter: RTL and testbench
=========================================

Name: reduction_tree_arbiter

Overview:
Shares one pipelined floating-point reduction tree between N_REQ requesters. Grants the tree to one requester per packet in round-robin order and drives the tree input port. Tags every issued beat with the owner ID through a delay line matched to the tree latency, and routes each tree result back to the owning requester. Sits between the per-channel vector producers and the reduction tree instance in the HFN datapath.

Parameters:
bitwidth, 16, element and result width (fp16 encoding)
N, 8, elements per vector beat (power of 2, ≥4)
N_REQ, 4, number of requesters (2..8)
TREE_LAT, 24, cycles from tree_in_valid to matching tree_out_valid; fixed by the adder configuration

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset; drive tree reset as ~rst
req_valid  in  N_REQ  per-requester beat valid
req_last  in  N_REQ  per-requester last beat of packet
req_data  in  N_REQ*N*bitwidth  requester i vector at [i*N*bitwidth +: N*bitwidth]
req_ready  out  N_REQ  beat accepted when req_valid[i] && req_ready[i]
tree_in  out  N*bitwidth  to tree vector input
tree_in_valid  out  1  to tree valid
tree_in_last  out  1  to tree last
tree_out  in  bitwidth  tree result
tree_out_valid  in  1  tree result valid
tree_out_last  in  1  tree result last
rsp_data  out  bitwidth  result, broadcast to all requesters
rsp_valid  out  N_REQ  one-hot result strobe for the owning requester
rsp_last  out  N_REQ  one-hot last strobe, qualified by rsp_valid
busy  out  1  high in GRANT state or while any tag is in flight
err  out  1  sticky tag/tree mismatch flag (see Optional Feature)

Behaviour:
- Reset: state IDLE, rr_ptr=0, grant=0, all tag stages invalid; req_ready, tree_in_valid, tree_in_last, rsp_valid, rsp_last, busy, err = 0; tree_in, rsp_data = 0.
- FSM IDLE: if any req_valid, latch grant = first requester with req_valid set, searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., N_REQ-1, 0, ...). Go to GRANT. No beat is accepted in IDLE.
- FSM GRANT: req_ready[grant]=1, all others 0. Ready is combinational from the state and grant registers only.
  - On an accepted beat, register tree_in=req_data slice, tree_in_valid=1, tree_in_last=req_last[grant] on the next cycle.
  - tree_in_valid is 0 on any cycle with no accepted beat.
  - An accepted beat with last=1 sets state to IDLE and rr_ptr=(grant+1) mod N_REQ.
  - Bubbles (req_valid low) within a packet hold the grant indefinitely.
- Packets are never interleaved. A requester dropping req_valid mid-packet does not release the grant.
- Tag delay line: TREE_LAT stages of {valid, id[$clog2(N_REQ)-1:0], last}.
  - Stage 0 loads {tree_in_valid, grant, tree_in_last} in the same cycle tree_in_valid is registered.
  - The line shifts every cycle; there is no backpressure anywhere.
- Output: when tree_out_valid is high, the next cycle has rsp_data=tree_out, rsp_valid[tag.id]=1, and rsp_last[tag.id]=tag.last. Otherwise rsp_valid=rsp_last=0 and rsp_data holds its last value.
- Latency: beat accepted at cycle t → tree_in_valid at t+1 → tree_out_valid at t+1+TREE_LAT → rsp_valid at t+2+TREE_LAT.
- Throughput: one beat per cycle within a packet. One idle cycle per packet boundary (IDLE arbitration).
- Single requester: it is re-granted after one IDLE cycle. Back-to-back single-beat packets therefore run at 1 beat per 2 cycles.
- busy = (state==GRANT) || OR of all tag valids.
- Reset mid-operation: the FSM and tag line clear immediately. The tree is flushed by the shared reset. No rsp_valid is asserted for beats accepted before reset.

Optional Feature:
Macro REDUCTION_ARB_CHECK_EN.
- Defined:
  - err sets when tree_out_valid differs from the final tag valid.
  - err also sets when both are valid and tree_out_last differs from the tag last.
  - err stays set until rst.
  - The check is masked for TREE_LAT+2 cycles after rst deasserts, using a down-counter.
  - Routing still follows the tag.
- Not defined: err is tied 0, no counter or comparator is built, and tree_out_last is unused.

Test Plan:
- Bench: tree model with TREE_LAT=24, fp16 add.
- Requester 1 only, one beat of eight 0x3C00 (1.0) with last → req_ready[1] high at cycle 2 after req_valid; rsp_valid=4'b0010, rsp_last=4'b0010, rsp_data=0x4800 (8.0), exactly 26 cycles after acceptance.
- All 4 requesters hold req_valid, each sending 2-beat packets → grant order 0,1,2,3,0; never two req_ready bits high; responses return in issue order with matching one-hot IDs.
- Requester 2 sends 5 beats with bubbles at beats 2 and 4 while requester 0 is also valid → requester 0 gets no ready until requester 2's last beat; rr_ptr becomes 3, so requester 0 wins next (wrap).
- Assert rst for 1 cycle with 10 beats in flight → no rsp_valid afterwards; busy=0 the cycle after reset; err stays 0.
- With REDUCTION_ARB_CHECK_EN defined, the model inserts one spurious tree_out_valid 30 cycles after reset → err=1 the next cycle and stays 1. Without the macro, err stays 0.
- Back-to-back single-beat packets from requester 3 only → tree_in_valid toggles 1,0,1,0; every rsp_valid is 4'b1000.

Source files
------------

// File: rtl/reduction_tree_arbiter.sv
// Round-robin arbiter sharing one pipelined reduction tree between N_REQ requesters.
// Define REDUCTION_ARB_CHECK_EN to build the sticky tag/tree consistency checker driving err.
module reduction_tree_arbiter #(
    parameter int bitwidth = 16,
    parameter int N        = 8,
    parameter int N_REQ    = 4,
    parameter int TREE_LAT = 24
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0]            req_last,
    input  logic [N_REQ*N*bitwidth-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    output logic [N*bitwidth-1:0]       tree_in,
    output logic                        tree_in_valid,
    output logic                        tree_in_last,
    input  logic [bitwidth-1:0]         tree_out,
    input  logic                        tree_out_valid,
    input  logic                        tree_out_last,
    output logic [bitwidth-1:0]         rsp_data,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [N_REQ-1:0]            rsp_last,
    output logic                        busy,
    output logic                        err
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int VW  = N * bitwidth;

    typedef enum logic {IDLE, GRANT} state_e;

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
        logic           last;
    } tag_t;

    state_e         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] pick;
    logic           found;
    logic           accept;

    logic [VW-1:0]  tree_in_q;
    logic           tree_in_valid_q;
    logic           tree_in_last_q;

    tag_t           tag_q [TREE_LAT];
    tag_t           tag_out;
    logic           tags_busy;

    logic [bitwidth-1:0] rsp_data_q;
    logic [N_REQ-1:0]    rsp_valid_q;
    logic [N_REQ-1:0]    rsp_last_q;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr_q;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (!found && req_valid[idx[IDW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        req_ready = '0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                req_ready[grant_q] = 1'b1;
                accept             = req_valid[grant_q];
                if (accept && req_last[grant_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = (int'(grant_q) == N_REQ - 1) ? '0 : grant_q + IDW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            rr_ptr_q        <= '0;
            grant_q         <= '0;
            tree_in_q       <= '0;
            tree_in_valid_q <= 1'b0;
            tree_in_last_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            grant_q         <= grant_d;
            tree_in_valid_q <= accept;
            tree_in_last_q  <= accept & req_last[grant_q];
            if (accept) begin
                tree_in_q <= req_data[int'(grant_q)*VW +: VW];
            end
        end
    end

    // grant_q still names the beat's owner while tree_in_valid is high, so stage 0 loads from the registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < TREE_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            tag_q[0] <= {tree_in_valid_q, grant_q, tree_in_last_q};
            for (int s = 1; s < TREE_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign tag_out = tag_q[TREE_LAT-1];

    always_comb begin
        tags_busy = 1'b0;
        for (int s = 0; s < TREE_LAT; s++) begin
            tags_busy = tags_busy | tag_q[s].valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data_q  <= '0;
            rsp_valid_q <= '0;
            rsp_last_q  <= '0;
        end else begin
            rsp_valid_q <= '0;
            rsp_last_q  <= '0;
            if (tree_out_valid) begin
                rsp_data_q               <= tree_out;
                rsp_valid_q[tag_out.id]  <= 1'b1;
                rsp_last_q[tag_out.id]   <= tag_out.last;
            end
        end
    end

`ifdef REDUCTION_ARB_CHECK_EN
    localparam int MW = $clog2(TREE_LAT + 3);

    logic [MW-1:0] mask_q;
    logic          err_q;
    logic          mismatch;

    assign mismatch = (tree_out_valid != tag_out.valid) ||
                      (tree_out_valid && tag_out.valid && (tree_out_last != tag_out.last));

    // The tree pipeline is still draining its own reset for a while, so ignore it until then.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= MW'(TREE_LAT + 2);
            err_q  <= 1'b0;
        end else begin
            if (mask_q != '0) begin
                mask_q <= mask_q - MW'(1);
            end else if (mismatch) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    logic unused_tree_out_last;
    assign unused_tree_out_last = tree_out_last;
    assign err = 1'b0;
`endif

    assign tree_in       = tree_in_q;
    assign tree_in_valid = tree_in_valid_q;
    assign tree_in_last  = tree_in_last_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_last      = rsp_last_q;
    assign busy          = (state_q == GRANT) || tags_busy;

endmodule

// File: tb/tb_reduction_tree_arbiter.sv
// Bench for reduction_tree_arbiter: fp16 tree model plus transaction-level round-robin/scoreboard model.
// Honours REDUCTION_ARB_CHECK_EN for the expected err behaviour.
module tb_reduction_tree_arbiter;
    localparam int W   = 16;
    localparam int N   = 8;
    localparam int NR  = 4;
    localparam int LAT = 24;
    localparam int VW  = N * W;

`ifdef REDUCTION_ARB_CHECK_EN
    localparam bit ERR_EXP = 1'b1;
`else
    localparam bit ERR_EXP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_last = '0;
    logic [NR*VW-1:0]  req_data = '0;
    logic [NR-1:0]     req_ready;
    logic [VW-1:0]     tree_in;
    logic              tree_in_valid;
    logic              tree_in_last;
    logic [W-1:0]      tree_out = '0;
    logic              tree_out_valid = 1'b0;
    logic              tree_out_last = 1'b0;
    logic [W-1:0]      rsp_data;
    logic [NR-1:0]     rsp_valid;
    logic [NR-1:0]     rsp_last;
    logic              busy;
    logic              err;

    reduction_tree_arbiter #(.bitwidth(W), .N(N), .N_REQ(NR), .TREE_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
        .tree_in(tree_in), .tree_in_valid(tree_in_valid), .tree_in_last(tree_in_last),
        .tree_out(tree_out), .tree_out_valid(tree_out_valid), .tree_out_last(tree_out_last),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_last(rsp_last),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [VW-1:0] data; bit last; int gap; } beat_t;
    typedef struct { int due; int id; bit last; logic [W-1:0] val; } exp_t;
    typedef struct { int due; logic [W-1:0] val; bit last; } tree_t;

    beat_t         reqQ[NR][$];
    exp_t          expQ[$];
    tree_t         treeQ[$];
    int            grantLog[$];
    int            cyc = 0;
    int            numChecks = 0;
    int            numFails = 0;
    int            rrModel = 0;
    int            owner = 0;
    bit            inPkt = 0;
    logic [NR-1:0] accNow = '0;
    logic [NR-1:0] prevValid = '0;
    bit            prevAcc = 0;
    logic [VW-1:0] prevData = '0;
    bit            prevLast = 0;
    int            lastAccCyc[NR];
    int            injectAt = -100;

    task automatic checkOutput(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] want);
        numChecks++;
        if (got !== want) begin
            numFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic int halfToInt(input logic [W-1:0] h);
        int e;
        int m;
        if (h[14:0] == 15'd0) return 0;
        e = int'(h[14:10]) - 15;
        m = 1024 + int'(h[9:0]);
        return m >>> (10 - e);
    endfunction

    function automatic logic [W-1:0] intToHalf(input int v);
        int e;
        int m;
        if (v <= 0) return '0;
        e = 0;
        while ((v >> (e + 1)) != 0) e++;
        m = (v << (10 - e)) & 32'h3FF;
        return {1'b0, 5'(e + 15), 10'(m)};
    endfunction

    // The tree is an fp16 adder over N lanes; bench data stays within exact small integers.
    function automatic logic [W-1:0] sumHalf(input logic [VW-1:0] v);
        int s;
        s = 0;
        for (int k = 0; k < N; k++) s += halfToInt(v[k*W +: W]);
        return intToHalf(s);
    endfunction

    function automatic logic [VW-1:0] randVec();
        logic [VW-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = intToHalf(int'($urandom_range(0, 15)));
        return v;
    endfunction

    function automatic bit pending();
        bit p;
        p = (expQ.size() != 0);
        for (int i = 0; i < NR; i++) if (reqQ[i].size() != 0) p = 1;
        return p;
    endfunction

    task automatic pushPacket(input int i, input int len, input int maxGap);
        for (int b = 0; b < len; b++) begin
            reqQ[i].push_back('{data: randVec(), last: (b == len - 1),
                                gap: int'($urandom_range(0, maxGap))});
        end
    endtask

    // Sampled on the falling edge: handshakes, tree input, scoreboard and tree model capture.
    task automatic monitor();
        int   id;
        int   expId;
        exp_t e;
        logic [NR-1:0] oh;
        checkOutput("ready_onehot", ($countones(req_ready) <= 1), 1'b1);
        accNow = rst ? '0 : (req_valid & req_ready);
        checkOutput("tree_in_valid", tree_in_valid, prevAcc);
        if (prevAcc) begin
            checkOutput("tree_in", tree_in, prevData);
            checkOutput("tree_in_last", tree_in_last, prevLast);
        end
        prevAcc = 0;
        if (accNow != '0) begin
            id = 0;
            for (int i = NR - 1; i >= 0; i--) if (accNow[i]) id = i;
            if (inPkt) begin
                checkOutput("owner", id, owner);
            end else begin
                expId = -1;
                for (int k = 0; k < NR; k++) begin
                    if (expId < 0 && prevValid[(rrModel + k) % NR]) expId = (rrModel + k) % NR;
                end
                checkOutput("grant", id, expId);
                owner = id;
                inPkt = 1;
                grantLog.push_back(id);
            end
            prevAcc  = 1;
            prevData = req_data[id*VW +: VW];
            prevLast = req_last[id];
            lastAccCyc[id] = cyc;
            expQ.push_back('{due: cyc + 2 + LAT, id: id, last: prevLast, val: sumHalf(prevData)});
            if (prevLast) begin
                inPkt   = 0;
                rrModel = (id + 1) % NR;
            end
        end
        if (tree_in_valid && !rst) begin
            treeQ.push_back('{due: cyc + LAT, val: sumHalf(tree_in), last: tree_in_last});
        end
        if (cyc != injectAt + 1) begin
            if (expQ.size() != 0 && expQ[0].due == cyc) begin
                e  = expQ.pop_front();
                oh = NR'(1 << e.id);
                checkOutput("rsp_valid", rsp_valid, oh);
                checkOutput("rsp_last", rsp_last, e.last ? oh : '0);
                checkOutput("rsp_data", rsp_data, e.val);
            end else begin
                checkOutput("rsp_idle", rsp_valid, '0);
            end
        end
        prevValid = rst ? '0 : req_valid;
    endtask

    // One clock cycle: drive requesters and tree model after the edge, then monitor.
    task automatic applyStimulus();
        beat_t b;
        tree_t t;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NR; i++) begin
            if (accNow[i] && reqQ[i].size() != 0) void'(reqQ[i].pop_front());
            if (reqQ[i].size() != 0 && reqQ[i][0].gap > 0) begin
                b = reqQ[i][0];
                b.gap = b.gap - 1;
                reqQ[i][0] = b;
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end else if (reqQ[i].size() != 0) begin
                req_valid[i] = 1'b1;
                req_last[i]  = reqQ[i][0].last;
                req_data[i*VW +: VW] = reqQ[i][0].data;
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
        accNow = '0;
        tree_out_valid = 1'b0;
        tree_out_last  = 1'b0;
        if (treeQ.size() != 0 && treeQ[0].due == cyc) begin
            t = treeQ.pop_front();
            tree_out       = t.val;
            tree_out_valid = 1'b1;
            tree_out_last  = t.last;
        end
        if (cyc == injectAt) begin
            tree_out       = 16'h1234;
            tree_out_valid = 1'b1;
            tree_out_last  = 1'b1;
        end
        @(negedge clk);
        monitor();
    endtask

    task automatic applyReset(input int n);
        rst = 1'b1;
        req_valid = '0;
        req_last  = '0;
        for (int i = 0; i < NR; i++) reqQ[i].delete();
        expQ.delete();
        treeQ.delete();
        inPkt = 0;
        rrModel = 0;
        prevAcc = 0;
        prevValid = '0;
        accNow = '0;
        repeat (n) applyStimulus();
        rst = 1'b0;
    endtask

    task automatic waitDrain(input string tag, input int budget);
        int n;
        n = 0;
        while (pending() && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput(tag, pending(), 1'b0);
    endtask

    initial begin
        int mark;
        int f;
        int relCyc;
        int tiv[$];

        // Reset state
        repeat (3) applyStimulus();
        checkOutput("rst_req_ready", req_ready, '0);
        checkOutput("rst_tree_in_valid", tree_in_valid, 1'b0);
        checkOutput("rst_tree_in_last", tree_in_last, 1'b0);
        checkOutput("rst_tree_in", tree_in, '0);
        checkOutput("rst_rsp_valid", rsp_valid, '0);
        checkOutput("rst_rsp_last", rsp_last, '0);
        checkOutput("rst_rsp_data", rsp_data, '0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_err", err, 1'b0);
        rst = 1'b0;
        repeat (2) applyStimulus();

        // Requester 1, single beat of eight 1.0 values
        reqQ[1].push_back('{data: {N{16'h3C00}}, last: 1'b1, gap: 0});
        applyStimulus();
        checkOutput("t1_ready_first", req_ready, '0);
        applyStimulus();
        checkOutput("t1_ready_second", req_ready, 4'b0010);
        repeat (5) applyStimulus();
        checkOutput("t1_busy", busy, 1'b1);
        f = 0;
        while (cyc < lastAccCyc[1] + 2 + LAT && f < 60) begin
            applyStimulus();
            f++;
        end
        checkOutput("t1_latency_bound", (cyc == lastAccCyc[1] + 2 + LAT), 1'b1);
        checkOutput("t1_rsp_valid", rsp_valid, 4'b0010);
        checkOutput("t1_rsp_last", rsp_last, 4'b0010);
        checkOutput("t1_rsp_data", rsp_data, 16'h4800);
        checkOutput("t1_busy_done", busy, 1'b0);
        waitDrain("t1_drain", 60);

        // Requester 2 long packet with bubbles while requester 0 waits; rr pointer now at 2
        mark = grantLog.size();
        reqQ[2].push_back('{data: randVec(), last: 1'b0, gap: 0});
        reqQ[2].push_back('{data: randVec(), last: 1'b0, gap: 2});
        reqQ[2].push_back('{data: randVec(), last: 1'b0, gap: 0});
        reqQ[2].push_back('{data: randVec(), last: 1'b0, gap: 1});
        reqQ[2].push_back('{data: randVec(), last: 1'b1, gap: 0});
        pushPacket(0, 1, 0);
        waitDrain("t3_drain", 120);
        checkOutput("t3_grant_count", grantLog.size() - mark, 2);
        if (grantLog.size() - mark >= 2) begin
            checkOutput("t3_first_grant", grantLog[mark], 2);
            checkOutput("t3_wrap_grant", grantLog[mark + 1], 0);
        end

        // Four requesters, two 2-beat packets each, starting from a fresh rr pointer
        applyReset(1);
        repeat (2) applyStimulus();
        mark = grantLog.size();
        for (int i = 0; i < NR; i++) begin
            pushPacket(i, 2, 0);
            pushPacket(i, 2, 0);
        end
        waitDrain("t2_drain", 200);
        checkOutput("t2_grant_count", grantLog.size() - mark, 8);
        if (grantLog.size() - mark >= 8) begin
            for (int k = 0; k < 8; k++) checkOutput("t2_grant_order", grantLog[mark + k], k % NR);
        end

        // Requester 3 alone, back-to-back single-beat packets
        for (int k = 0; k < 4; k++) pushPacket(3, 1, 0);
        f = 0;
        while (pending() && f < 80) begin
            applyStimulus();
            tiv.push_back(int'(tree_in_valid));
            f++;
        end
        checkOutput("t6_drain", pending(), 1'b0);
        f = -1;
        foreach (tiv[k]) if (f < 0 && tiv[k] == 1) f = k;
        checkOutput("t6_pattern_found", (f >= 0 && f + 7 <= tiv.size()), 1'b1);
        if (f >= 0 && f + 7 <= tiv.size()) begin
            for (int k = 0; k < 7; k++) checkOutput("t6_toggle", tiv[f + k], (k % 2 == 0) ? 1 : 0);
        end

        // Randomised traffic on all requesters
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (reqQ[i].size() == 0 && $urandom_range(0, 3) == 0) begin
                    pushPacket(i, int'($urandom_range(1, 4)), int'($urandom_range(0, 2)));
                end
            end
            applyStimulus();
        end
        waitDrain("rand_drain", 400);
        checkOutput("rand_err", err, 1'b0);

        // Reset with beats in flight
        pushPacket(0, 14, 0);
        repeat (12) applyStimulus();
        checkOutput("inflight_busy", busy, 1'b1);
        applyReset(1);
        applyStimulus();
        relCyc = cyc;
        checkOutput("post_rst_busy", busy, 1'b0);
        checkOutput("post_rst_err", err, 1'b0);

        // Spurious tree result 30 cycles after reset release
        injectAt = relCyc + 30;
        while (cyc < injectAt) applyStimulus();
        checkOutput("pre_inject_err", err, 1'b0);
        applyStimulus();
        checkOutput("inject_err", err, ERR_EXP);
        repeat (10) applyStimulus();
        checkOutput("inject_err_sticky", err, ERR_EXP);
        checkOutput("final_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
